multicycle_control_unit: RTL and testbench

FSM-based control unit for the multi-cycle RV32I core, the successor to the single-cycle controller. One shared ALU and one unified instruction/data memory are sequenced over 3–5 cycles per instruction. It adds stall-on-memory handshaking, branch-type decoding (beq/bne/blt/bge), jalr, lui, sticky illegal-instruction detection and a retired-instruction counter. It sits beside the multi-cycle data path and drives all of its enables and muxes.

---
 rtl/riscv_pkg.sv | 63 ++++++
 rtl/alu_decoder.sv | 53 +++++
 rtl/multicycle_control_unit.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RV32I control path.
// Opcodes, FSM states and the mux/ALU select codes.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR1,
    S_JALR2,
    S_LUI,
    S_ILLEGAL
  } state_t;

  typedef enum logic [1:0] {
    AOP_ADD,
    AOP_BR,
    AOP_FN
  } aluop_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// ALU operation select plus funct3 legality check
// for the multi-cycle controller.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  aluop_t     aluop,
  output logic [2:0] alucontrol,
  output logic       f3_illegal
);

  always_comb begin
    alucontrol = ALU_ADD;
    unique case (aluop)
      AOP_ADD: alucontrol = ALU_ADD;
      AOP_BR:  alucontrol = funct3[2] ? ALU_SLT : ALU_SUB;
      AOP_FN: begin
        case (funct3)
          3'b000: alucontrol =
            (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

  always_comb begin
    f3_illegal = 1'b0;
    unique case (1'b1)
      (op == OP_LOAD),
      (op == OP_STORE):
        f3_illegal = (funct3 != 3'b010);
      (op == OP_JALR):
        f3_illegal = (funct3 != 3'b000);
      (op == OP_BR):
        f3_illegal = funct3[1];
      (op == OP_R),
      (op == OP_I):
        f3_illegal = !(funct3 == 3'b000 ||
                       funct3 == 3'b010 ||
                       funct3 == 3'b110 ||
                       funct3 == 3'b111);
      default: f3_illegal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// FSM controller sequencing the shared ALU and unified memory
// of the multi-cycle RV32I data path.
module multicycle_control_unit
  import riscv_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUControl,
  output logic [2:0]       ImmSrc,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_t state, state_n;
  aluop_t aluop;

  logic rdy;
  logic f3_bad;
  logic taken;
  logic pcupdate;
  logic memw;
  logic irw;
  logic regw;
  logic retire;
  logic illegal_q;
  logic [CNT_W-1:0] instret_q;

  assign rdy = (MEM_WAIT != 0) ? mem_ready : 1'b1;

  // bne/blt invert Zero; beq/bge use it directly
  assign taken = Zero ^ funct3[0] ^ funct3[2];

  alu_decoder u_dec (
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7[5]),
    .aluop      (aluop),
    .alucontrol (ALUControl),
    .f3_illegal (f3_bad)
  );

  always_comb begin
    ImmSrc = IMM_I;
    unique case (1'b1)
      (op == OP_STORE): ImmSrc = IMM_S;
      (op == OP_BR):    ImmSrc = IMM_B;
      (op == OP_JAL):   ImmSrc = IMM_J;
      (op == OP_LUI):   ImmSrc = IMM_U;
      default:          ImmSrc = IMM_I;
    endcase
  end

  always_comb begin
    state_n   = state;
    aluop     = AOP_ADD;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    pcupdate  = 1'b0;
    memw      = 1'b0;
    irw       = 1'b0;
    regw      = 1'b0;
    retire    = 1'b0;
    unique case (state)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        irw       = rdy;
        pcupdate  = rdy;
        if (rdy) state_n = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        if (f3_bad) state_n = S_ILLEGAL;
        else begin
          case (op)
            OP_LOAD:  state_n = S_MEMADR;
            OP_STORE: state_n = S_MEMADR;
            OP_R:     state_n = S_EXECR;
            OP_I:     state_n = S_EXECI;
            OP_BR:    state_n = S_BRANCH;
            OP_JAL:   state_n = S_JAL;
            OP_JALR:  state_n = S_JALR1;
            OP_LUI:   state_n = S_LUI;
            default:  state_n = S_ILLEGAL;
          endcase
        end
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_n = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (rdy) state_n = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        regw      = 1'b1;
        retire    = 1'b1;
        state_n   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        memw   = rdy;
        retire = rdy;
        if (rdy) state_n = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        aluop   = AOP_FN;
        state_n = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        aluop   = AOP_FN;
        state_n = S_ALUWB;
      end
      S_ALUWB: begin
        regw    = 1'b1;
        retire  = 1'b1;
        state_n = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = SRCA_RS1;
        aluop   = AOP_BR;
        retire  = 1'b1;
        state_n = S_FETCH;
      end
      S_JAL, S_JALR2: begin
        ALUSrcA  = SRCA_OLDPC;
        ALUSrcB  = SRCB_FOUR;
        pcupdate = 1'b1;
        state_n  = S_ALUWB;
      end
      S_JALR1: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_n = S_JALR2;
      end
      S_LUI: begin
        ResultSrc = RES_IMM;
        regw      = 1'b1;
        retire    = 1'b1;
        state_n   = S_FETCH;
      end
      S_ILLEGAL: state_n = S_ILLEGAL;
      default:   state_n = S_FETCH;
    endcase
  end

  assign PCWrite  = !reset &
    (pcupdate | ((state == S_BRANCH) & taken));
  assign MemWrite = !reset & memw;
  assign IRWrite  = !reset & irw;
  assign RegWrite = !reset & regw;
  assign illegal  = illegal_q;
  assign instret  = instret_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state <= state_n;
      if (state_n == S_ILLEGAL) illegal_q <= 1'b1;
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: a stalling/4-bit
// counter instance and a no-wait/32-bit instance share stimulus.
module tb_multicycle_control_unit;

  logic clk = 1'b0;
  logic reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic Zero;
  logic mem_ready;

  logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;
  logic [3:0] instret;

  logic PCWrite_0, AdrSrc_0, MemWrite_0, IRWrite_0;
  logic RegWrite_0, illegal_0;
  logic [1:0] ResultSrc_0, ALUSrcA_0, ALUSrcB_0;
  logic [2:0] ALUControl_0, ImmSrc_0;
  logic [31:0] instret_0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(.MEM_WAIT(1), .CNT_W(4)) u1 (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3),
    .funct7(funct7), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .illegal(illegal), .instret(instret)
  );

  multicycle_control_unit #(.MEM_WAIT(0), .CNT_W(32)) u0 (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3),
    .funct7(funct7), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite_0), .AdrSrc(AdrSrc_0),
    .MemWrite(MemWrite_0), .IRWrite(IRWrite_0),
    .RegWrite(RegWrite_0), .ResultSrc(ResultSrc_0),
    .ALUSrcA(ALUSrcA_0), .ALUSrcB(ALUSrcB_0),
    .ALUControl(ALUControl_0), .ImmSrc(ImmSrc_0),
    .illegal(illegal_0), .instret(instret_0)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic rst();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
  endtask

  function automatic logic [31:0] wen();
    return 32'({PCWrite, IRWrite, RegWrite, MemWrite});
  endfunction

  task automatic do_branch(input logic [2:0] f3,
                           input logic z,
                           input logic exp_pc,
                           input logic [2:0] exp_alu);
    op = 7'b1100011; funct3 = f3; Zero = z;
    rst();
    cyc();
    cyc();
    chk("br_alu", 32'(ALUControl), 32'(exp_alu));
    chk("br_pcw", 32'(PCWrite), 32'(exp_pc));
    chk("br_srca", 32'(ALUSrcA), 32'd2);
    cyc();
    chk("br_fetch", 32'(IRWrite), 32'd1);
    chk("br_ret", 32'(instret), 32'd1);
  endtask

  initial begin
    reset = 1'b1; op = 7'b0110011; funct3 = 3'b000;
    funct7 = 7'b0100000; Zero = 1'b0; mem_ready = 1'b1;

    // reset state and forced-off enables
    @(posedge clk);
    #1;
    chk("rst_irw", 32'(IRWrite), 32'd0);
    chk("rst_pcw", 32'(PCWrite), 32'd0);
    chk("rst_ill", 32'(illegal), 32'd0);
    chk("rst_cnt", 32'(instret), 32'd0);
    reset = 1'b0;
    #1;

    // R-type sub
    chk("f_irw", 32'(IRWrite), 32'd1);
    chk("f_pcw", 32'(PCWrite), 32'd1);
    chk("f_srcb", 32'(ALUSrcB), 32'd2);
    chk("f_res", 32'(ResultSrc), 32'd2);
    cyc();
    chk("d_srca", 32'(ALUSrcA), 32'd1);
    chk("d_srcb", 32'(ALUSrcB), 32'd1);
    chk("d_alu", 32'(ALUControl), 32'd0);
    cyc();
    chk("er_alu", 32'(ALUControl), 32'd1);
    chk("er_srca", 32'(ALUSrcA), 32'd2);
    chk("er_srcb", 32'(ALUSrcB), 32'd0);
    chk("er_regw", 32'(RegWrite), 32'd0);
    cyc();
    chk("wb_regw", 32'(RegWrite), 32'd1);
    chk("wb_cnt0", 32'(instret), 32'd0);
    cyc();
    chk("r_cnt1", 32'(instret), 32'd1);
    chk("r_cnt1_0", instret_0, 32'd1);
    chk("r_fetch", 32'(IRWrite), 32'd1);

    // I-type addi: funct7[5] must not turn into sub
    op = 7'b0010011;
    rst();
    cyc();
    cyc();
    chk("ei_alu", 32'(ALUControl), 32'd0);
    chk("ei_srcb", 32'(ALUSrcB), 32'd1);
    funct3 = 3'b111;
    #1;
    chk("ei_and", 32'(ALUControl), 32'd2);

    // lw with a 3-cycle stall in MEMREAD
    op = 7'b0000011; funct3 = 3'b010; funct7 = 7'd0;
    rst();
    cyc();
    cyc();
    chk("ma_srca", 32'(ALUSrcA), 32'd2);
    mem_ready = 1'b0;
    cyc();
    chk("mr_adr", 32'(AdrSrc), 32'd1);
    chk("mr_regw", 32'(RegWrite), 32'd0);
    cyc();
    chk("mr_nowait0", 32'(RegWrite_0), 32'd1);
    for (int i = 0; i < 2; i++) begin
      chk("mr_hold", 32'(AdrSrc), 32'd1);
      chk("mr_hold_regw", 32'(RegWrite), 32'd0);
      cyc();
    end
    mem_ready = 1'b1;
    #1;
    chk("mr_last", 32'(AdrSrc), 32'd1);
    cyc();
    chk("mwb_regw", 32'(RegWrite), 32'd1);
    chk("mwb_res", 32'(ResultSrc), 32'd1);
    cyc();
    chk("lw_cnt", 32'(instret), 32'd1);

    // sw with stalls in FETCH and MEMWRITE
    op = 7'b0100011;
    rst();
    mem_ready = 1'b0;
    #1;
    chk("sf_stall", 32'(IRWrite), 32'd0);
    chk("sf_nowait0", 32'(IRWrite_0), 32'd1);
    cyc();
    mem_ready = 1'b1;
    #1;
    chk("sf_go", 32'(IRWrite), 32'd1);
    cyc();
    cyc();
    chk("sw_imm", 32'(ImmSrc), 32'd1);
    cyc();
    mem_ready = 1'b0;
    #1;
    chk("sw_wait", 32'(MemWrite), 32'd0);
    cyc();
    mem_ready = 1'b1;
    #1;
    chk("sw_memw", 32'(MemWrite), 32'd1);
    chk("sw_cnt0", 32'(instret), 32'd0);
    cyc();
    chk("sw_cnt1", 32'(instret), 32'd1);

    // branches
    do_branch(3'b000, 1'b1, 1'b1, 3'b001);
    do_branch(3'b001, 1'b1, 1'b0, 3'b001);
    do_branch(3'b100, 1'b0, 1'b1, 3'b101);
    do_branch(3'b101, 1'b0, 1'b0, 3'b101);

    // jalr
    op = 7'b1100111; funct3 = 3'b000;
    rst();
    cyc();
    cyc();
    chk("j1_srca", 32'(ALUSrcA), 32'd2);
    chk("j1_srcb", 32'(ALUSrcB), 32'd1);
    chk("j1_alu", 32'(ALUControl), 32'd0);
    chk("j1_pcw", 32'(PCWrite), 32'd0);
    cyc();
    chk("j2_pcw", 32'(PCWrite), 32'd1);
    chk("j2_srcb", 32'(ALUSrcB), 32'd2);
    chk("j2_srca", 32'(ALUSrcA), 32'd1);
    cyc();
    chk("jwb_regw", 32'(RegWrite), 32'd1);
    cyc();
    chk("jalr_cnt", 32'(instret), 32'd1);

    // unknown opcode and bad branch funct3 both trap
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin op = 7'd0; funct3 = 3'b000; end
      else begin op = 7'b1100011; funct3 = 3'b010; end
      rst();
      cyc();
      chk("il_dec", 32'(illegal), 32'd0);
      cyc();
      for (int i = 0; i < 10; i++) begin
        chk("il_flag", 32'(illegal), 32'd1);
        chk("il_wen", wen(), 32'd0);
        cyc();
      end
      reset = 1'b1;
      #1;
      chk("il_rst_wen", wen(), 32'd0);
      cyc();
      reset = 1'b0;
      #1;
      chk("il_clr", 32'(illegal), 32'd0);
      chk("il_fetch", 32'(IRWrite), 32'd1);
    end

    // reset in MEMREAD aborts without retire
    op = 7'b0000011; funct3 = 3'b010;
    rst();
    cyc();
    cyc();
    mem_ready = 1'b0;
    cyc();
    chk("ab_mr", 32'(AdrSrc), 32'd1);
    reset = 1'b1; mem_ready = 1'b1;
    #1;
    chk("ab_regw", 32'(RegWrite), 32'd0);
    cyc();
    reset = 1'b0;
    #1;
    chk("ab_fetch", 32'(IRWrite), 32'd1);
    chk("ab_cnt", 32'(instret), 32'd0);
    chk("ab_regw2", 32'(RegWrite), 32'd0);

    // 16 lui: 4-bit counter wraps, 32-bit does not
    op = 7'b0110111; funct3 = 3'b000;
    rst();
    for (int i = 0; i < 16; i++) begin
      if (i == 1) chk("lui_cnt1", 32'(instret), 32'd1);
      cyc();
      cyc();
      if (i == 0) begin
        chk("lui_res", 32'(ResultSrc), 32'd3);
        chk("lui_regw", 32'(RegWrite), 32'd1);
        chk("lui_imm", 32'(ImmSrc), 32'd4);
      end
      cyc();
    end
    chk("lui_wrap", 32'(instret), 32'd0);
    chk("lui_cnt_0", instret_0, 32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
